// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: reads back an active-low, time-multiplexed 7-segment bus.
// The inputs are registered, and each digit's pattern is decoded back to BCD.
// Complete frames are assembled, and a frame is published only after it has
// repeated for STABLE_SCANS consecutive scans.
// Build option: define SEG7_ALT_GLYPH_EN to accept the tailless 6 and 9 and
// the 7 with segment f lit.
module seg7_scan_capture #(
    parameter int DIGITS       = 4,
    parameter int STABLE_SCANS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     err,
    output logic                  valid,
    output logic                  scan_err
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_SCANS);

    // Returns {err, code}. The segment order is a..g, MSB first, and lit segments are 0.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = {1'b0, 4'd0};
            7'b1001111: decode = {1'b0, 4'd1};
            7'b0010010: decode = {1'b0, 4'd2};
            7'b0000110: decode = {1'b0, 4'd3};
            7'b1001100: decode = {1'b0, 4'd4};
            7'b0100100: decode = {1'b0, 4'd5};
            7'b0100000: decode = {1'b0, 4'd6};
            7'b0001111: decode = {1'b0, 4'd7};
            7'b0000000: decode = {1'b0, 4'd8};
            7'b0000100: decode = {1'b0, 4'd9};
            7'b1111111: decode = {1'b0, 4'hF};
`ifdef SEG7_ALT_GLYPH_EN
            7'b1100000: decode = {1'b0, 4'd6};
            7'b0001100: decode = {1'b0, 4'd9};
            7'b0001101: decode = {1'b0, 4'd7};
`endif
            default:    decode = {1'b1, 4'hE};
        endcase
    endfunction

    // Stage 1 registers
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
    // Stage 2 registers: the frame being assembled
    logic [4*DIGITS-1:0] slot_bcd_q, slot_bcd_d;
    logic [DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic                frame_done_q, frame_done_d;
    logic                scan_err_q, scan_err_d;
    // Stage 3 registers: the stability tracker and the published outputs
    logic [4*DIGITS-1:0] prev_bcd_q, prev_bcd_d;
    logic [DIGITS-1:0]   prev_err_q, prev_err_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                valid_q, valid_d;

    logic [DIGITS-1:0]   sel;
    logic                sel_none, sel_multi;
    logic [4:0]          dec;
    logic                frame_match, publish;

    assign sel       = ~an_q;
    assign sel_none  = (sel == '0);
    assign sel_multi = ((sel & (sel - 1'b1)) != '0);
    assign dec       = decode(seg_q);

    // Stage 2 writes the decoded sample into its slot and detects when a frame is complete.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        slot_bcd_d   = slot_bcd_q;
        slot_err_d   = slot_err_q;
        seen_d       = seen_q;
        frame_done_d = 1'b0;
        scan_err_d   = 1'b0;
        if (sel_multi) begin
            seen_d     = '0;
            scan_err_d = 1'b1;
        end else if (!sel_none) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel[i]) begin
                    slot_bcd_d[4*i +: 4] = dec[3:0];
                    slot_err_d[i]        = dec[4];
                end
            end
            seen_d = seen_q | sel;
            if (&seen_d) begin
                frame_done_d = 1'b1;
                seen_d       = '0;
            end
        end
    end

    // Stage 3 compares the completed frame with the previous one and publishes it once it is stable.
    always_comb begin
        prev_bcd_d  = prev_bcd_q;
        prev_err_d  = prev_err_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        err_d       = err_q;
        valid_d     = 1'b0;
        publish     = 1'b0;
        frame_match = (slot_bcd_q == prev_bcd_q) && (slot_err_q == prev_err_q);
        if (frame_done_q) begin
            if (frame_match) begin
                if (cnt_q < STABLE_CNT) cnt_d = cnt_q + 4'd1;
                publish = (cnt_q == STABLE_CNT - 4'd1);
            end else begin
                cnt_d      = 4'd1;
                prev_bcd_d = slot_bcd_q;
                prev_err_d = slot_err_q;
                publish    = (STABLE_CNT == 4'd1);
            end
            if (publish) begin
                bcd_d   = slot_bcd_q;
                err_d   = slot_err_q;
                valid_d = 1'b1;
            end
        end
        // An illegal select breaks the scan, so stability must be rebuilt from scratch.
        if (sel_multi) cnt_d = 4'd0;
    end

    // All state registers, with a synchronous reset that returns the block to idle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register reads pre-edge values.
        if (rst) begin
            seg_q        <= '1;
            an_q         <= '1;
            slot_bcd_q   <= '0;
            slot_err_q   <= '0;
            seen_q       <= '0;
            frame_done_q <= 1'b0;
            scan_err_q   <= 1'b0;
            prev_bcd_q   <= '0;
            prev_err_q   <= '0;
            cnt_q        <= 4'd0;
            bcd_q        <= '1;
            err_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            seg_q        <= seg;
            an_q         <= an;
            slot_bcd_q   <= slot_bcd_d;
            slot_err_q   <= slot_err_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_done_d;
            scan_err_q   <= scan_err_d;
            prev_bcd_q   <= prev_bcd_d;
            prev_err_q   <= prev_err_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
        end
    end

    assign bcd      = bcd_q;
    assign err      = err_q;
    assign valid    = valid_q;
    assign scan_err = scan_err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with DIGITS=4 and STABLE_SCANS=2.
// Expected values are hand-computed; the alternate-glyph expectation follows SEG7_ALT_GLYPH_EN.
module tb_seg7_scan_capture;

    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                           P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                           P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000,
                           P9 = 7'b0000100, PBLANK = 7'b1111111,
                           PBAD = 7'b0110000, PALT6 = 7'b1100000;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        valid;
    logic        scan_err;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int scnt   = 0;

    seg7_scan_capture #(.DIGITS(4), .STABLE_SCANS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg      (seg),
        .an       (an),
        .bcd      (bcd),
        .err      (err),
        .valid    (valid),
        .scan_err (scan_err)
    );

    always #5 clk = ~clk;

    // Count the output pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid)    vcnt <= vcnt + 1;
        if (scan_err) scnt <= scnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [3:0] an_v, input logic [6:0] seg_v);
        @(negedge clk);
        an  = an_v;
        seg = seg_v;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) put(4'b1111, PBLANK);
    endtask

    // Presents digits 0..3 in turn; the last sample is still on the bus when this returns.
    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        put(4'b1110, s0);
        put(4'b1101, s1);
        put(4'b1011, s2);
        put(4'b0111, s3);
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'b1111;
        seg = PBLANK;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_bcd", 32'(bcd), 32'h0000FFFF);
        check("reset_err", 32'(err), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_scan_err", 32'(scan_err), 32'h0);
        idle(4);
        check("idle_no_valid", 32'(vcnt), 32'd0);

        // A stable frame publishes 3 edges after the last sample of the second scan.
        scan(P1, P2, P3, P4);
        idle(3);
        check("stable_first_scan", 32'(vcnt), 32'd0);
        scan(P1, P2, P3, P4);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 2) check("stable_bcd_held", 32'(bcd), 32'h0000FFFF);
            check($sformatf("stable_valid_t%0d", k), 32'(valid), (k == 3) ? 32'h1 : 32'h0);
            an  = 4'b1111;
            seg = PBLANK;
        end
        check("stable_bcd", 32'(bcd), 32'h00004321);
        check("stable_err", 32'(err), 32'h0);
        scan(P1, P2, P3, P4);
        idle(5);
        check("stable_no_repulse", 32'(vcnt), 32'd1);

        // An unstable frame must repeat before it is published.
        scan(P5, P6, P7, P8);
        idle(3);
        scan(P5, P6, P7, P9);
        idle(3);
        check("unstable_hold", 32'(vcnt), 32'd1);
        check("unstable_bcd_old", 32'(bcd), 32'h00004321);
        scan(P5, P6, P7, P9);
        idle(5);
        check("unstable_pub", 32'(vcnt), 32'd2);
        check("unstable_bcd", 32'(bcd), 32'h00009765);

        // A bad pattern and a blank digit.
        scan(P0, PBLANK, PBAD, P8);
        idle(3);
        scan(P0, PBLANK, PBAD, P8);
        idle(5);
        check("bad_pub", 32'(vcnt), 32'd3);
        check("bad_bcd", 32'(bcd), 32'h00008EF0);
        check("bad_err", 32'(err), 32'h4);

        // An illegal select mid-frame needs two fresh full frames before the next publish.
        scan(P3, P3, P3, P3);
        idle(3);
        put(4'b1110, P3);
        put(4'b1101, P3);
        put(4'b1100, P3);
        @(negedge clk);
        check("scan_err_t1", 32'(scan_err), 32'h0);
        an  = 4'b1111;
        seg = PBLANK;
        @(negedge clk);
        check("scan_err_t2", 32'(scan_err), 32'h1);
        idle(3);
        check("scan_err_count", 32'(scnt), 32'd1);
        scan(P3, P3, P3, P3);
        idle(5);
        check("illegal_needs_two", 32'(vcnt), 32'd3);
        scan(P3, P3, P3, P3);
        idle(5);
        check("illegal_pub", 32'(vcnt), 32'd4);
        check("illegal_bcd", 32'(bcd), 32'h00003333);

        // The alternate glyph decodes only when the option is built in.
        scan(PALT6, P0, P0, P0);
        idle(3);
        scan(PALT6, P0, P0, P0);
        idle(5);
        check("alt_pub", 32'(vcnt), 32'd5);
`ifdef SEG7_ALT_GLYPH_EN
        check("alt_bcd", 32'(bcd), 32'h00000006);
        check("alt_err", 32'(err), 32'h0);
`else
        check("alt_bcd", 32'(bcd), 32'h0000000E);
        check("alt_err", 32'(err), 32'h1);
`endif

        // A reset mid-frame restores the reset outputs, and capture then restarts.
        put(4'b1110, P1);
        put(4'b1101, P2);
        @(negedge clk);
        rst = 1'b1;
        an  = 4'b1111;
        seg = PBLANK;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_bcd", 32'(bcd), 32'h0000FFFF);
        check("midrst_err", 32'(err), 32'h0);
        scan(P1, P2, P3, P4);
        idle(3);
        scan(P1, P2, P3, P4);
        idle(5);
        check("midrst_pub", 32'(vcnt), 32'd6);
        check("midrst_bcd_pub", 32'(bcd), 32'h00004321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Capture block for a time-multiplexed, active-low 7-segment display bus: it samples the segment/digit-select lines, turns each digit's segment pattern back into a BCD code, assembles complete display frames and publishes a frame only once it has held stable for a set number of scans. It is the reverse of the lab's BCD-to-7-segment decoder. It sits on the display side of the lab board, so a bench or checker can read back what a display driver is actually showing.

## Interface
- `DIGITS`, 4: number of multiplexed digits (1–8).
- `STABLE_SCANS`, 2: number of consecutive identical complete frames required before publishing (1–15).
- `clk` input, 1: single clock; every register updates on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `seg` input, 7: segment lines, active-low; `seg[6]`=a, `seg[5]`=b, `seg[4]`=c, `seg[3]`=d, `seg[2]`=e, `seg[1]`=f, `seg[0]`=g.
- `an` input, DIGITS: digit selects, active-low, one-hot. `an[i]` low means `seg` carries digit i.
- `bcd` output, 4*DIGITS: published codes; digit i occupies `bcd[4i+3:4i]`.
- `err` output, DIGITS: per-digit flag, set when that digit's pattern was unrecognised.
- `valid` output, 1: one-cycle pulse marking an update of `bcd`/`err`.
- `scan_err` output, 1: one-cycle pulse when a sample has more than one `an` bit low.

## Operation
- **Stage 1:** `seg` and `an` are registered every cycle with no qualification.
- **Stage 2 (decode), exact-match table:**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Blank, 1111111 → code 4'hF, err 0.
  - Any other pattern → code 4'hE, err 1.
- **Stage 2 (select handling):**
  - `an` all high: sample ignored.
  - Exactly one bit low (digit i): the decoded code and err are written to slot i, and `seen[i]` is set. A repeat of the same digit within a frame overwrites its slot.
  - Two or more bits low: sample discarded, `seen` cleared, `scan_err` pulsed, match count cleared.
- **Frame completion:** a frame is complete in the cycle in which `seen` becomes all-ones. `seen` then clears for the next frame.
- **Stage 3 (stability):**
  - On each complete frame, compare the slot contents with the previous complete frame. If equal, increment the match count, saturating at STABLE_SCANS. Otherwise set it to 1 and store the frame as the new previous frame.
  - When the count first reaches STABLE_SCANS, load `bcd`/`err` from the frame and pulse `valid`.
  - Further identical frames do not pulse `valid` again. A changed frame must rebuild the count before it can publish.
  - With STABLE_SCANS=1, every frame that differs from the previous one publishes immediately.
- **Reset values:** `bcd` = all 4'hF, `err`=0, `valid`=0, `scan_err`=0. Slots, `seen`, the previous frame and the match count are all cleared.
- **Reset mid-frame:** partial frames are discarded, and capture restarts at the first sample after `rst` deasserts.

## Timing
- Input present before edge N:
  - registered at N;
  - slot written at N+1;
  - if it completes a publishing frame, `bcd`/`err` change and `valid` is high for the cycle following edge N+2.
- `scan_err` is high for the cycle following edge N+1 after an illegal `an` sample at edge N.
- `bcd`/`err` change only together with a `valid` pulse, or on reset.
- No backpressure. A new digit may be presented every cycle, and back-to-back publishes are legal.
- A frame-completing sample and a stage-3 publish of the prior frame cannot collide, because a frame needs at least DIGITS samples.

## Configuration
- `SEG7_ALT_GLYPH_EN`:
  - **Defined:** three additional patterns decode with err 0.
    - 6 without its tail, 1100000 → 6.
    - 9 without its tail, 0001100 → 9.
    - 7 with segment f lit, 0001101 → 7.
  - **Undefined:** those patterns decode to 4'hE with err 1.
- No other behaviour changes.

## Test plan
- **Reset:** with `rst`=1 for 2 cycles, then idle with `an`=4'b1111 → `bcd`=16'hFFFF, `err`=0, `valid` never pulses.
- **Stable frame:** DIGITS=4, STABLE_SCANS=2, scan digits 0..3 showing 1,2,3,4 twice → `valid` pulses once, 3 edges after the last sample of scan 2. `bcd`=16'h4321, `err`=0. A third identical scan gives no pulse.
- **Unstable frame:** scan 5,6,7,8, then 5,6,7,9, then 5,6,7,9 → one `valid`, with `bcd`=16'h9765.
- **Bad pattern:** digit 2 shows 0110000 twice → `bcd[11:8]`=4'hE, `err`=4'b0100. Digit 1 shows 1111111 → `bcd[7:4]`=4'hF and `err[1]`=0.
- **Illegal select:** `an`=4'b1100 mid-frame → `scan_err` pulse. The partial frame is dropped, and the next publish requires two full fresh frames.
- **Alternate glyph:** 1100000 on digit 0, tested in both builds → `bcd[3:0]`=6 with `err[0]`=0 when `SEG7_ALT_GLYPH_EN` is defined. Without it, 4'hE and `err[0]`=1.
